// File: rtl/inference_seq_pkg.sv
// Shared types and constants for the inference sequencer: FSM state encoding,
// controller register offsets, observation geometry and two helpers that build
// the address and write data for one observation register.
package inference_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_MODE,
      ST_WAIT_B_MODE,
      ST_WR_OBS,
      ST_WAIT_B_OBS,
      ST_RD_RES,
      ST_WAIT_R,
      ST_OUT,
      ST_ERROR
   } state_t;

   // Controller register offsets relative to the result register base
   localparam logic [31:0] REG_RESULT = 32'h0000_0000;
   localparam logic [31:0] REG_OBS0   = 32'h0000_000C;
   localparam logic [31:0] REG_MODE   = 32'h0000_001C;

   // Observation geometry: four 9-bit {row[5:0],col[2:0]} fields per beat
   localparam int OBS_W = 9;
   localparam int N_OBS = 4;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Byte address of observation register k
   function automatic logic [31:0] obs_addr(input logic [31:0] base, input logic [1:0] k);
      return base + REG_OBS0 + {28'b0, k, 2'b00};
   endfunction

   // Zero-extended observation field k of a packed beat
   function automatic logic [31:0] obs_word(input logic [OBS_W*N_OBS-1:0] obs, input logic [1:0] k);
      return {{(32-OBS_W){1'b0}}, obs[OBS_W*k +: OBS_W]};
   endfunction

endpackage

// File: rtl/infseq_argmax.sv
// Registered argmax over the four unsigned bytes of a result word.
// Ties resolve to the lowest byte index. One cycle of latency: the class is
// captured on the same edge that captures the word when en_i is high.
// Only instantiated when INFSEQ_ARGMAX_EN is defined.
module infseq_argmax
   import inference_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] word_i,
   output logic [1:0]  class_o
);

   logic [1:0] best_idx;
   logic [7:0] best_val;
   logic [1:0] class_q;

   // Scan bytes upward; a strict compare keeps the earliest maximum on ties
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned
      // (which would infer a latch); blocking '=' is correct in combinational logic.
      best_idx = 2'd0;
      best_val = word_i[7:0];
      for (int i = 1; i < 4; i++) begin
         if (word_i[8*i +: 8] > best_val) begin
            best_val = word_i[8*i +: 8];
            best_idx = 2'(i);
         end
      end
   end

   // Capture the winning index alongside the result word
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking '<=' so all flops update together.
      if (rst_i) begin
         class_q <= 2'd0;
      end else if (en_i) begin
         class_q <= best_idx;
      end
   end

   assign class_o = class_q;

endmodule

// File: rtl/inference_sequencer.sv
// AXI-lite master feeding the Bayesian chip controller. Per accepted
// observation beat it (optionally) rewrites the stoch/log mode register,
// writes the four observation registers, reads the 4x8-bit result word and
// presents it downstream. One transaction in flight; any bad response, stray
// response or timeout parks the FSM in ERROR until err_clr_i.
// Optional feature: define INFSEQ_ARGMAX_EN to drive res_class_o with the
// argmax byte index of the result; otherwise res_class_o is tied to 0.
module inference_sequencer
   import inference_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int          TIMEOUT_CYC = 4096
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   // AXI-lite write address / data / response
   output logic [31:0]            axi_aw_addr_o,
   output logic                   axi_aw_valid_o,
   input  logic                   axi_aw_ready_i,
   output logic [31:0]            axi_w_data_o,
   output logic [3:0]             axi_w_strb_o,
   output logic                   axi_w_valid_o,
   input  logic                   axi_w_ready_i,
   input  logic [1:0]             axi_b_resp_i,
   input  logic                   axi_b_valid_i,
   output logic                   axi_b_ready_o,
   // AXI-lite read address / data
   output logic [31:0]            axi_ar_addr_o,
   output logic                   axi_ar_valid_o,
   input  logic                   axi_ar_ready_i,
   input  logic [31:0]            axi_r_data_i,
   input  logic [1:0]             axi_r_resp_i,
   input  logic                   axi_r_valid_i,
   output logic                   axi_r_ready_o,
   // Observation stream
   input  logic                   cfg_log_i,
   input  logic                   obs_valid_i,
   output logic                   obs_ready_o,
   input  logic [OBS_W*N_OBS-1:0] obs_data_i,
   // Result stream
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [31:0]            res_data_o,
   output logic [1:0]             res_class_o,
   // Error
   output logic                   err_o,
   input  logic                   err_clr_i
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   state_t                   state_q;
   logic [1:0]               k_q;
   logic [OBS_W*N_OBS-1:0]   obs_q;
   logic                     cfg_q;
   logic                     mode_q;
   logic                     mode_vld_q;
   logic [TMO_W-1:0]         tmo_q;
   logic                     rdy_q;
   logic                     aw_valid_q;
   logic                     w_valid_q;
   logic                     ar_valid_q;
   logic [31:0]              aw_addr_q;
   logic [31:0]              w_data_q;
   logic                     obs_ready_q;
   logic                     res_valid_q;
   logic [31:0]              res_data_q;
   logic                     err_q;

   logic in_wait_b;
   logic counting;
   logic timeout_hit;
   logic stray_rsp;
   logic bad_rsp;
   logic error_evt;

   // Classify the current cycle: timeout, unexpected or failing responses
   always_comb begin
      in_wait_b   = (state_q == ST_WAIT_B_MODE) || (state_q == ST_WAIT_B_OBS);
      counting    = state_q inside {ST_WR_MODE, ST_WAIT_B_MODE, ST_WR_OBS,
                                    ST_WAIT_B_OBS, ST_RD_RES, ST_WAIT_R};
      timeout_hit = counting && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
      stray_rsp   = rdy_q && ((axi_b_valid_i && !in_wait_b) ||
                              (axi_r_valid_i && (state_q != ST_WAIT_R)));
      bad_rsp     = (in_wait_b && axi_b_valid_i && (axi_b_resp_i != AXI_RESP_OKAY)) ||
                    ((state_q == ST_WAIT_R) && axi_r_valid_i && (axi_r_resp_i != AXI_RESP_OKAY));
      error_evt   = timeout_hit || stray_rsp || bad_rsp;
   end

   // Sequencer FSM with all handshake outputs registered
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         k_q         <= 2'd0;
         obs_q       <= '0;
         cfg_q       <= 1'b0;
         mode_q      <= 1'b0;
         mode_vld_q  <= 1'b0;
         tmo_q       <= '0;
         rdy_q       <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         aw_addr_q   <= '0;
         w_data_q    <= '0;
         obs_ready_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (counting) begin
            tmo_q <= tmo_q + 1'b1;
         end

         if (error_evt) begin
            // Error has priority over every transition, including err_clr_i
            state_q     <= ST_ERROR;
            err_q       <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            obs_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            mode_vld_q  <= 1'b0;
            obs_q       <= '0;
            tmo_q       <= '0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (obs_valid_i && obs_ready_q) begin
                     obs_q       <= obs_data_i;
                     cfg_q       <= cfg_log_i;
                     obs_ready_q <= 1'b0;
                     aw_valid_q  <= 1'b1;
                     w_valid_q   <= 1'b1;
                     tmo_q       <= '0;
                     if (!mode_vld_q || (cfg_log_i != mode_q)) begin
                        state_q   <= ST_WR_MODE;
                        aw_addr_q <= BASE_ADDR + REG_MODE;
                        w_data_q  <= {31'b0, cfg_log_i};
                     end else begin
                        state_q   <= ST_WR_OBS;
                        k_q       <= 2'd0;
                        aw_addr_q <= obs_addr(BASE_ADDR, 2'd0);
                        w_data_q  <= obs_word(obs_data_i, 2'd0);
                     end
                  end else begin
                     obs_ready_q <= 1'b1;
                  end
               end

               ST_WR_MODE, ST_WR_OBS: begin
                  if (axi_aw_ready_i && axi_w_ready_i) begin
                     aw_valid_q <= 1'b0;
                     w_valid_q  <= 1'b0;
                     tmo_q      <= '0;
                     state_q    <= (state_q == ST_WR_MODE) ? ST_WAIT_B_MODE : ST_WAIT_B_OBS;
                  end
               end

               ST_WAIT_B_MODE: begin
                  if (axi_b_valid_i) begin
                     mode_q     <= cfg_q;
                     mode_vld_q <= 1'b1;
                     k_q        <= 2'd0;
                     aw_addr_q  <= obs_addr(BASE_ADDR, 2'd0);
                     w_data_q   <= obs_word(obs_q, 2'd0);
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     tmo_q      <= '0;
                     state_q    <= ST_WR_OBS;
                  end
               end

               ST_WAIT_B_OBS: begin
                  if (axi_b_valid_i) begin
                     tmo_q <= '0;
                     if (k_q == 2'(N_OBS - 1)) begin
                        ar_valid_q <= 1'b1;
                        state_q    <= ST_RD_RES;
                     end else begin
                        k_q        <= k_q + 2'd1;
                        aw_addr_q  <= obs_addr(BASE_ADDR, k_q + 2'd1);
                        w_data_q   <= obs_word(obs_q, k_q + 2'd1);
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= ST_WR_OBS;
                     end
                  end
               end

               ST_RD_RES: begin
                  if (axi_ar_ready_i) begin
                     ar_valid_q <= 1'b0;
                     tmo_q      <= '0;
                     state_q    <= ST_WAIT_R;
                  end
               end

               ST_WAIT_R: begin
                  if (axi_r_valid_i) begin
                     res_data_q  <= axi_r_data_i;
                     res_valid_q <= 1'b1;
                     state_q     <= ST_OUT;
                  end
               end

               ST_OUT: begin
                  if (res_ready_i) begin
                     res_valid_q <= 1'b0;
                     obs_ready_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end
               end

               ST_ERROR: begin
                  if (err_clr_i) begin
                     err_q       <= 1'b0;
                     mode_vld_q  <= 1'b0;
                     obs_ready_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign axi_aw_addr_o  = aw_addr_q;
   assign axi_aw_valid_o = aw_valid_q;
   assign axi_w_data_o   = w_data_q;
   assign axi_w_strb_o   = 4'hF;
   assign axi_w_valid_o  = w_valid_q;
   assign axi_b_ready_o  = rdy_q;
   assign axi_ar_addr_o  = BASE_ADDR + REG_RESULT;
   assign axi_ar_valid_o = ar_valid_q;
   assign axi_r_ready_o  = rdy_q;
   assign obs_ready_o    = obs_ready_q;
   assign res_valid_o    = res_valid_q;
   assign res_data_o     = res_data_q;
   assign err_o          = err_q;

`ifdef INFSEQ_ARGMAX_EN
   logic argmax_en;
   logic [1:0] argmax_class;

   // Capture the class on the same edge that captures res_data_q
   assign argmax_en = (state_q == ST_WAIT_R) && axi_r_valid_i && !error_evt;

   infseq_argmax u_argmax (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (argmax_en),
      .word_i  (axi_r_data_i),
      .class_o (argmax_class)
   );

   assign res_class_o = argmax_class;
`else
   assign res_class_o = 2'd0;
`endif

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed self-checking bench for inference_sequencer with a simple always-ready
// AXI-lite slave model that logs every write and read address.
module tb_inference_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] aw_addr, w_data, ar_addr, r_data;
   logic        aw_valid, aw_ready, w_valid, w_ready;
   logic [3:0]  w_strb;
   logic [1:0]  b_resp, r_resp, res_class;
   logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
   logic        cfg_log, obs_valid, obs_ready, res_valid, res_ready, err, err_clr;
   logic [35:0] obs_data;
   logic [31:0] res_data;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef INFSEQ_ARGMAX_EN
   localparam bit ARGMAX = 1'b1;
`else
   localparam bit ARGMAX = 1'b0;
`endif

   // Slave model controls and logs
   logic [31:0] rd_data  = '0;
   bit          r_mute   = 1'b0;
   bit          bad_en   = 1'b0;
   logic [31:0] bad_addr = '0;
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   logic [31:0] rd_addr_log[$];
   logic [31:0] exp_a[5];
   logic [31:0] exp_d[5];

   always #5 clk = ~clk;

   inference_sequencer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .axi_aw_addr_o  (aw_addr),
      .axi_aw_valid_o (aw_valid),
      .axi_aw_ready_i (aw_ready),
      .axi_w_data_o   (w_data),
      .axi_w_strb_o   (w_strb),
      .axi_w_valid_o  (w_valid),
      .axi_w_ready_i  (w_ready),
      .axi_b_resp_i   (b_resp),
      .axi_b_valid_i  (b_valid),
      .axi_b_ready_o  (b_ready),
      .axi_ar_addr_o  (ar_addr),
      .axi_ar_valid_o (ar_valid),
      .axi_ar_ready_i (ar_ready),
      .axi_r_data_i   (r_data),
      .axi_r_resp_i   (r_resp),
      .axi_r_valid_i  (r_valid),
      .axi_r_ready_o  (r_ready),
      .cfg_log_i      (cfg_log),
      .obs_valid_i    (obs_valid),
      .obs_ready_o    (obs_ready),
      .obs_data_i     (obs_data),
      .res_valid_o    (res_valid),
      .res_ready_i    (res_ready),
      .res_data_o     (res_data),
      .res_class_o    (res_class),
      .err_o          (err),
      .err_clr_i      (err_clr)
   );

   // Always-ready slave: one-cycle B / R response after each accepted request
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         b_valid <= 1'b0;
         b_resp  <= 2'b00;
         r_valid <= 1'b0;
         r_resp  <= 2'b00;
         r_data  <= '0;
      end else begin
         if (aw_valid && w_valid) begin
            wr_addr_log.push_back(aw_addr);
            wr_data_log.push_back(w_data);
            b_valid <= 1'b1;
            b_resp  <= (bad_en && aw_addr == bad_addr) ? 2'b10 : 2'b00;
         end else if (b_ready) begin
            b_valid <= 1'b0;
         end
         if (ar_valid) begin
            rd_addr_log.push_back(ar_addr);
            if (!r_mute) begin
               r_valid <= 1'b1;
               r_data  <= rd_data;
            end
         end else if (r_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      rd_addr_log.delete();
   endtask

   task automatic send_beat(input logic cfg, input logic [35:0] data);
      int n = 0;
      @(negedge clk);
      while (!obs_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("obs_ready before beat", {31'b0, obs_ready}, 32'd1);
      cfg_log   = cfg;
      obs_data  = data;
      obs_valid = 1'b1;
      @(negedge clk);
      obs_valid = 1'b0;
   endtask

   task automatic get_result(output logic [31:0] data, output logic [1:0] cls);
      int n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("res_valid rise", {31'b0, res_valid}, 32'd1);
      data      = res_data;
      cls       = res_class;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("res_valid drop", {31'b0, res_valid}, 32'd0);
   endtask

   task automatic check_log(input string tag, input int n);
      check({tag, " wr count"}, wr_addr_log.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < wr_addr_log.size()) begin
            check($sformatf("%s wr%0d addr", tag, i), wr_addr_log[i], exp_a[i]);
            check($sformatf("%s wr%0d data", tag, i), wr_data_log[i], exp_d[i]);
         end
      end
      check({tag, " rd count"}, rd_addr_log.size(), 1);
      if (rd_addr_log.size() > 0) check({tag, " rd addr"}, rd_addr_log[0], 32'h2000);
   endtask

   task automatic wait_err(input int budget);
      int n = 0;
      while (!err && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("err raised", {31'b0, err}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  c;
      int n;
      int bad;

      aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
      cfg_log = 1'b0; obs_valid = 1'b0; obs_data = '0; res_ready = 1'b0; err_clr = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      #3;
      check("rst aw_valid", {31'b0, aw_valid}, 0);
      check("rst w_valid", {31'b0, w_valid}, 0);
      check("rst ar_valid", {31'b0, ar_valid}, 0);
      check("rst b_ready", {31'b0, b_ready}, 0);
      check("rst r_ready", {31'b0, r_ready}, 0);
      check("rst obs_ready", {31'b0, obs_ready}, 0);
      check("rst res_valid", {31'b0, res_valid}, 0);
      check("rst res_data", res_data, 0);
      check("rst res_class", {30'b0, res_class}, 0);
      check("rst err", {31'b0, err}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post-rst b_ready", {31'b0, b_ready}, 1);
      check("post-rst r_ready", {31'b0, r_ready}, 1);
      check("post-rst obs_ready", {31'b0, obs_ready}, 1);

      // 1: first beat writes mode, then four observations, then reads result
      clear_logs();
      rd_data = 32'h7F00_FF01;
      send_beat(1'b1, {9'h1FF, 9'h000, 9'h055, 9'h0AA});
      get_result(d, c);
      check("t1 res_data", d, 32'h7F00_FF01);
      check("t1 res_class", {30'b0, c}, ARGMAX ? 32'd1 : 32'd0);
      exp_a = '{32'h201C, 32'h200C, 32'h2010, 32'h2014, 32'h2018};
      exp_d = '{32'h1, 32'h0AA, 32'h055, 32'h0, 32'h1FF};
      check_log("t1", 5);

      // 2: same mode, no mode write
      clear_logs();
      rd_data = 32'h1080_4020;
      send_beat(1'b1, {9'h123, 9'h0F0, 9'h00F, 9'h101});
      get_result(d, c);
      check("t2 res_data", d, 32'h1080_4020);
      check("t2 res_class", {30'b0, c}, ARGMAX ? 32'd2 : 32'd0);
      exp_a = '{32'h200C, 32'h2010, 32'h2014, 32'h2018, 32'h0};
      exp_d = '{32'h101, 32'h00F, 32'h0F0, 32'h123, 32'h0};
      check_log("t2", 4);

      // 3: mode toggles to stoch, all-equal bytes tie to class 0
      clear_logs();
      rd_data = 32'h4040_4040;
      send_beat(1'b0, {9'h001, 9'h002, 9'h003, 9'h004});
      get_result(d, c);
      check("t3 res_data", d, 32'h4040_4040);
      check("t3 res_class", {30'b0, c}, 0);
      exp_a = '{32'h201C, 32'h200C, 32'h2010, 32'h2014, 32'h2018};
      exp_d = '{32'h0, 32'h004, 32'h003, 32'h002, 32'h001};
      check_log("t3", 5);

      // 4: downstream backpressure holds the result stable
      clear_logs();
      rd_data = 32'hA5A5_0001;
      send_beat(1'b0, 36'h0);
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (res_valid !== 1'b1 || res_data !== 32'hA5A5_0001 || obs_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      check("t4 hold stable", bad, 0);
      get_result(d, c);
      check("t4 res_data", d, 32'hA5A5_0001);
      @(negedge clk);
      check("t4 obs_ready back", {31'b0, obs_ready}, 1);

      // 5: error response on second observation write
      clear_logs();
      bad_en   = 1'b1;
      bad_addr = 32'h2010;
      send_beat(1'b0, {9'h011, 9'h022, 9'h033, 9'h044});
      wait_err(200);
      repeat (5) @(negedge clk);
      check("t5 err sticky", {31'b0, err}, 1);
      check("t5 obs_ready", {31'b0, obs_ready}, 0);
      check("t5 aw_valid", {31'b0, aw_valid}, 0);
      check("t5 ar_valid", {31'b0, ar_valid}, 0);
      check("t5 wr count", wr_addr_log.size(), 2);
      check("t5 no read", rd_addr_log.size(), 0);
      bad_en  = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t5 err cleared", {31'b0, err}, 0);
      check("t5 obs_ready after clr", {31'b0, obs_ready}, 1);
      clear_logs();
      rd_data = 32'h0102_0304;
      send_beat(1'b0, {9'h011, 9'h022, 9'h033, 9'h044});
      get_result(d, c);
      check("t5 res_data", d, 32'h0102_0304);
      check("t5 res_class", {30'b0, c}, 0);
      exp_a = '{32'h201C, 32'h200C, 32'h2010, 32'h2014, 32'h2018};
      exp_d = '{32'h0, 32'h044, 32'h033, 32'h022, 32'h011};
      check_log("t5 rewrite", 5);

      // 6: read response never arrives -> timeout
      clear_logs();
      r_mute = 1'b1;
      send_beat(1'b0, 36'h1);
      n = 0;
      while (rd_addr_log.size() == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6 read issued", rd_addr_log.size(), 1);
      repeat (4000) @(negedge clk);
      check("t6 no early timeout", {31'b0, err}, 0);
      wait_err(300);
      check("t6 res_valid", {31'b0, res_valid}, 0);
      r_mute  = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t6 err cleared", {31'b0, err}, 0);

      // 6b: asynchronous reset while an observation write is pending
      send_beat(1'b1, {9'h1FF, 9'h000, 9'h055, 9'h0AA});
      n = 0;
      while (!(aw_valid && aw_addr == 32'h2010) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t6 mid-WR_OBS reached", {31'b0, aw_valid}, 1);
      #1 rst = 1'b1;
      #1;
      check("t6 async aw_valid", {31'b0, aw_valid}, 0);
      check("t6 async w_valid", {31'b0, w_valid}, 0);
      check("t6 async ar_valid", {31'b0, ar_valid}, 0);
      check("t6 async b_ready", {31'b0, b_ready}, 0);
      check("t6 async obs_ready", {31'b0, obs_ready}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6 obs_ready after rst", {31'b0, obs_ready}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
